// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file address range through a spare
// asynchronous read port and streams {address, data} beats over valid/ready.
// Optional build macro: REG_DUMP_CHECKSUM_EN adds a running sum of accepted
// beat data on the checksum output.
module reg_dump_reader #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [ADDRESS_WIDTH-1:0] first_addr,
   input  logic [ADDRESS_WIDTH-1:0] last_addr,
   output logic [ADDRESS_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0]    rf_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDRESS_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
`ifdef REG_DUMP_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]    checksum
`endif
);

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] addr;       // walk pointer, also drives the RF port
   logic [ADDRESS_WIDTH-1:0] last;       // end of range, latched on start
   logic                     accept;     // start taken in IDLE
   logic                     capture;    // READ cycle completes, beat loaded
   logic                     hs;         // beat handed off to the consumer
   logic                     advance;    // handshake on a non-final beat
   logic                     finish;     // handshake on the final beat

   // The read port sees the walk pointer directly; data returns in the same cycle.
   assign rf_addr = addr;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; abort overrides everything and lands in IDLE.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = SEND;
            SEND:    if (out_valid && out_ready) state_nxt = out_last ? IDLE : READ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Control strobes decoded from state; abort masks every one of them.
   always_comb begin
      accept  = (state == IDLE) && start && !abort;
      capture = (state == READ) && !abort;
      hs      = (state == SEND) && out_valid && out_ready && !abort;
      advance = hs && !out_last;
      finish  = hs && out_last;
   end

   // Address walk and end-of-range latch; the increment wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
         last <= '0;
      end else if (accept) begin
         addr <= first_addr;
         last <= last_addr;
      end else if (advance) begin
         addr <= addr + ADDR_ONE;
      end
   end

   // Beat register: loaded at the end of READ, held through SEND until handoff.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_addr  <= addr;
         out_data  <= rf_data;
         out_last  <= (addr == last);
      end else if (hs || abort) begin
         out_valid <= 1'b0;
      end
   end

   // Status: busy follows the state register, done pulses once after the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= finish;
      end
   end

`ifdef REG_DUMP_CHECKSUM_EN
   // Running sum of accepted beats; an abort keeps the partial sum.
   always_ff @(posedge clk) begin
      if (rst || accept) checksum <= '0;
      else if (hs)       checksum <= checksum + out_data;
   end
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a behavioural register file feeds
// the read port and a queue-based model predicts each dump's beats.
module tb_reg_dump_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [4:0]  first_addr;
   logic [4:0]  last_addr;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   logic [31:0] rf [32];
   int          n_cmp = 0;
   int          n_err = 0;

   assign rf_data = rf[rf_addr];

   always #5 clk = ~clk;

   reg_dump_reader #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
`ifdef REG_DUMP_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      chk(tag, 32'(out_valid), 32'd1);
   endtask

   // Full dump of first..last with randomized backpressure. stall forces
   // ready low for that many valid cycles first; glitch_addr >= 0 pulses a
   // stray start while that beat is on the bus.
   task automatic run_dump(input int first, input int last, input int pct,
                           input int stall, input int glitch_addr, input string nm);
      int          q_a[$];
      logic [31:0] q_d[$];
      logic [31:0] sum = 0;
      int          n, cycles, beats, st;
      bit          hs, glitched, was_last;
      n = ((last - first + 32) % 32) + 1;
      for (int i = 0; i < n; i++) begin
         q_a.push_back((first + i) % 32);
         q_d.push_back(rf[(first + i) % 32]);
         sum += rf[(first + i) % 32];
      end
      st = stall; glitched = 0; beats = 0; cycles = 0;
      first_addr = 5'(first); last_addr = 5'(last); start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      chk({nm, "_read_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_read_busy"}, 32'(busy), 32'd1);
      chk({nm, "_read_rfaddr"}, 32'(rf_addr), 32'(first));
      while (q_a.size() > 0 && cycles < 2000) begin
         if (st > 0 && out_valid) begin
            out_ready = 1'b0;
            st--;
         end else begin
            out_ready = ($urandom_range(99) < pct);
         end
         if (glitch_addr >= 0 && !glitched && out_valid && out_addr == 5'(glitch_addr)) begin
            start = 1'b1; first_addr = 5'($urandom); last_addr = 5'($urandom);
            glitched = 1;
         end else begin
            start = 1'b0;
         end
         if (out_valid) begin
            chk({nm, "_addr"}, 32'(out_addr), 32'(q_a[0]));
            chk({nm, "_data"}, out_data, q_d[0]);
            chk({nm, "_last"}, 32'(out_last), 32'(q_a.size() == 1));
         end
         hs = out_valid && out_ready;
         tick();
         cycles++;
         if (hs) begin
            void'(q_a.pop_front());
            void'(q_d.pop_front());
            beats++;
            was_last = (q_a.size() == 0);
            chk({nm, "_done"}, 32'(done), 32'(was_last));
            chk({nm, "_gap_valid"}, 32'(out_valid), 32'd0);
            if (was_last) chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
         end
      end
      start = 1'b0;
      chk({nm, "_beats"}, 32'(beats), 32'(n));
      out_ready = 1'b0;
      tick();
      chk({nm, "_done_clear"}, 32'(done), 32'd0);
      chk({nm, "_stay_idle"}, 32'(busy), 32'd0);
`ifdef REG_DUMP_CHECKSUM_EN
      chk({nm, "_checksum"}, checksum, sum);
`endif
   endtask

   initial begin
      rf[0] = 32'd0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      rst = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
      first_addr = 5'd3; last_addr = 5'd9;

      // Reset held with start and ready high: nothing moves.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_rfaddr", 32'(rf_addr), 32'd0);
         chk("rst_oaddr", 32'(out_addr), 32'd0);
         chk("rst_odata", out_data, 32'd0);
         chk("rst_olast", 32'(out_last), 32'd0);
`ifdef REG_DUMP_CHECKSUM_EN
         chk("rst_checksum", checksum, 32'd0);
`endif
      end
      start = 1'b0; out_ready = 1'b0; rst = 1'b0;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Basic range 1..4.
      rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[4] = 32'h44;
      run_dump(1, 4, 100, 0, -1, "basic");

      // Wrap-around 30..1, x0 reads as 0.
      rf[30] = 32'hA; rf[31] = 32'hB; rf[1] = 32'hC;
      run_dump(30, 1, 100, 0, -1, "wrap");

      // Single beat under 7 cycles of backpressure.
      rf[5] = 32'hDEADBEEF;
      run_dump(5, 5, 100, 7, -1, "bp");

      // Abort on the second beat of 0..31.
      first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("abort_beat1");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_valid("abort_beat2");
      chk("abort_beat2_addr", 32'(out_addr), 32'd1);
      abort = 1'b1; out_ready = 1'b1;
      tick();
      abort = 1'b0; out_ready = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      tick();
      chk("abort_done2", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      run_dump(2, 2, 100, 0, -1, "after_abort");

      // Stray start while busy is dropped.
      run_dump(0, 7, 70, 0, 3, "glitch");

      // Reset mid-dump stops the stream immediately.
      first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("midrst_valid_pre");
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rfaddr", 32'(rf_addr), 32'd0);
      tick();
      chk("midrst_idle", 32'(busy), 32'd0);

      // Randomized ranges, contents and backpressure.
      for (int t = 0; t < 12; t++) begin
         for (int i = 1; i < 32; i++) rf[i] = $urandom;
         run_dump(int'($urandom_range(31)), int'($urandom_range(31)), 60, 0, -1, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
